arb_mux4: RTL



---
 rtl/arb_mux4.sv | 105 ++++++++++
 1 files changed

// File: rtl/arb_mux4.sv
// Four-requester round-robin arbiter that steers a shared 4:1 mux of requester
// words into one output register with a valid/ready handshake.
module arb_mux4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    // Output handshake: a word moves to the consumer on a rising edge where
    // out_valid and out_ready are both 1; out_data is stable while out_valid
    // is 1 and out_ready is 0.
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             load_en;
    logic             win;
    logic [1:0]       win_idx;
    logic [1:0]       scan_idx;
    logic [1:0]       mux_sel;
    logic [WIDTH-1:0] mux_ab, mux_cd, mux_out;

    assign load_en = !out_valid_q || out_ready;

    // Rotating priority scan starting at ptr_q; reset suppresses any grant.
    always_comb begin
        win      = 1'b0;
        win_idx  = 2'd0;
        scan_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!win && req[scan_idx]) begin
                win     = 1'b1;
                win_idx = scan_idx;
            end
        end
        if (!load_en || reset) begin
            win = 1'b0;
        end
    end

    always_comb begin
        gnt     = 4'b0000;
        mux_sel = sel_q;
        if (win) begin
            gnt          = 4'b0000;
            gnt[win_idx] = 1'b1;
            mux_sel      = win_idx;
        end
    end

    assign s0 = mux_sel[0];
    assign s1 = mux_sel[1];

    // Two-level mux2 tree: s0 picks within each pair, s1 picks the pair.
    assign mux_ab  = s0 ? b : a;
    assign mux_cd  = s0 ? d : c;
    assign mux_out = s1 ? mux_cd : mux_ab;

    always_comb begin
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (win) begin
            out_data_d  = mux_out;
            out_valid_d = 1'b1;
            ptr_d       = win_idx + 2'd1;
            sel_d       = win_idx;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= 2'd0;
            sel_q       <= 2'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
